// File: rtl/vram_arbiter.sv
// Video SRAM sequencer: arbitrates screen, CPU, ULAplus and DMA requesters
// onto one registered SETUP/STROBE/HOLD access cycle.
module vram_arbiter #(
  parameter int ACC_CYCLES   = 2,
  parameter int DMA_MAX_WAIT = 7
) (
  input  logic        clk28,
  input  logic        rst_n,
  input  logic        scr_req,
  input  logic [18:0] scr_addr,
  output logic        scr_ack,
  output logic [7:0]  scr_data,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [18:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  input  logic        up_req,
  input  logic [5:0]  up_addr,
  input  logic [7:0]  up_wdata,
  output logic        up_ack,
  input  logic        dma_req,
  input  logic        dma_wr,
  input  logic [18:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  output logic [7:0]  dma_rdata,
  output logic        dma_ack,
  output logic [18:0] va,
  input  logic [7:0]  vd_in,
  output logic [7:0]  vd_out,
  output logic        vd_oe,
  output logic        n_vrd,
  output logic        n_vwr,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE, SETUP, STROBE, HOLD
  } state_t;

  typedef enum logic [1:0] {
    ID_SCR, ID_CPU, ID_UP, ID_DMA
  } req_id_t;

  localparam logic [1:0] CNT_INIT = 2'(ACC_CYCLES - 1);
  localparam logic [3:0] WAIT_MAX = 4'(DMA_MAX_WAIT);

  state_t      state_q, state_d;
  req_id_t     id_q, id_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [18:0] va_q, va_d;
  logic [7:0]  vd_out_q, vd_out_d;
  logic        vd_oe_q, vd_oe_d;
  logic        n_vrd_q, n_vrd_d;
  logic        n_vwr_q, n_vwr_d;
  logic [3:0]  ack_q, ack_d;
  logic [7:0]  scr_data_q, scr_data_d;
  logic [7:0]  cpu_rdata_q, cpu_rdata_d;
  logic [7:0]  dma_rdata_q, dma_rdata_d;
  logic [3:0]  dma_wait_q, dma_wait_d;

  logic        arb_pt, promote, any_req;
  logic        sel_scr, sel_dma_hi, sel_cpu;
  logic        sel_up, sel_dma_lo;
  req_id_t     gnt_id;
  logic        gnt_wr;
  logic [18:0] gnt_addr;
  logic [7:0]  gnt_wdata;

  assign arb_pt  = (state_q == IDLE) || (state_q == HOLD);
  assign promote = dma_req && (dma_wait_q >= WAIT_MAX);
  assign any_req = scr_req | cpu_req | up_req | dma_req;

  // Mutually exclusive grant terms; promoted DMA overtakes CPU and ULAplus
  assign sel_scr    = scr_req;
  assign sel_dma_hi = !scr_req && promote;
  assign sel_cpu    = !scr_req && !promote && cpu_req;
  assign sel_up     = !scr_req && !promote && !cpu_req && up_req;
  assign sel_dma_lo = !scr_req && !promote && !cpu_req
                   && !up_req && dma_req;

  always_comb begin
    gnt_id    = id_q;
    gnt_wr    = 1'b0;
    gnt_addr  = va_q;
    gnt_wdata = vd_out_q;
    unique case (1'b1)
      sel_scr: begin
        gnt_id   = ID_SCR;
        gnt_addr = scr_addr;
      end
      sel_cpu: begin
        gnt_id    = ID_CPU;
        gnt_wr    = cpu_wr;
        gnt_addr  = cpu_addr;
        gnt_wdata = cpu_wdata;
      end
      sel_up: begin
        gnt_id    = ID_UP;
        gnt_wr    = 1'b1;
        gnt_addr  = {2'b00, 3'b111, 8'hFF, up_addr};
        gnt_wdata = up_wdata;
      end
      sel_dma_hi, sel_dma_lo: begin
        gnt_id    = ID_DMA;
        gnt_wr    = dma_wr;
        gnt_addr  = dma_addr;
        gnt_wdata = dma_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    va_d        = va_q;
    vd_out_d    = vd_out_q;
    vd_oe_d     = vd_oe_q;
    n_vrd_d     = 1'b1;
    n_vwr_d     = 1'b1;
    ack_d       = 4'b0000;
    scr_data_d  = scr_data_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    unique case (state_q)
      IDLE, HOLD: begin
        state_d = IDLE;
        vd_oe_d = 1'b0;
        if (any_req) begin
          state_d  = SETUP;
          id_d     = gnt_id;
          wr_d     = gnt_wr;
          va_d     = gnt_addr;
          vd_out_d = gnt_wdata;
          vd_oe_d  = gnt_wr;
        end
      end
      SETUP: begin
        state_d = STROBE;
        cnt_d   = CNT_INIT;
        n_vrd_d = wr_q;
        n_vwr_d = !wr_q;
      end
      STROBE: begin
        if (cnt_q == 2'd0) begin
          state_d = HOLD;
          ack_d   = 4'b0001 << id_q;
          if (!wr_q) begin
            unique case (id_q)
              ID_SCR: scr_data_d  = vd_in;
              ID_CPU: cpu_rdata_d = vd_in;
              ID_DMA: dma_rdata_d = vd_in;
              ID_UP:  ;
            endcase
          end
        end else begin
          cnt_d   = cnt_q - 2'd1;
          n_vrd_d = n_vrd_q;
          n_vwr_d = n_vwr_q;
        end
      end
    endcase
  end

  // Wait count only moves at arbitration points, but a dropped request clears it
  always_comb begin
    dma_wait_d = dma_wait_q;
    if (!dma_req) begin
      dma_wait_d = 4'd0;
    end else if (arb_pt) begin
      if (sel_dma_hi || sel_dma_lo) begin
        dma_wait_d = 4'd0;
      end else if (dma_wait_q != 4'hF) begin
        dma_wait_d = dma_wait_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk28) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      id_q        <= ID_SCR;
      cnt_q       <= 2'd0;
      wr_q        <= 1'b0;
      va_q        <= 19'd0;
      vd_out_q    <= 8'd0;
      vd_oe_q     <= 1'b0;
      n_vrd_q     <= 1'b1;
      n_vwr_q     <= 1'b1;
      ack_q       <= 4'b0000;
      scr_data_q  <= 8'd0;
      cpu_rdata_q <= 8'd0;
      dma_rdata_q <= 8'd0;
      dma_wait_q  <= 4'd0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      va_q        <= va_d;
      vd_out_q    <= vd_out_d;
      vd_oe_q     <= vd_oe_d;
      n_vrd_q     <= n_vrd_d;
      n_vwr_q     <= n_vwr_d;
      ack_q       <= ack_d;
      scr_data_q  <= scr_data_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
      dma_wait_q  <= dma_wait_d;
    end
  end

  assign va        = va_q;
  assign vd_out    = vd_out_q;
  assign vd_oe     = vd_oe_q;
  assign n_vrd     = n_vrd_q;
  assign n_vwr     = n_vwr_q;
  assign scr_ack   = ack_q[ID_SCR];
  assign cpu_ack   = ack_q[ID_CPU];
  assign up_ack    = ack_q[ID_UP];
  assign dma_ack   = ack_q[ID_DMA];
  assign scr_data  = scr_data_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: access shape, priority, DMA promotion,
// mid-access reset and cancelled requests.
module tb_vram_arbiter;

  logic        clk28 = 1'b0;
  logic        rst_n;
  logic        scr_req;
  logic [18:0] scr_addr;
  logic        scr_ack;
  logic [7:0]  scr_data;
  logic        cpu_req, cpu_wr;
  logic [18:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        cpu_ack;
  logic        up_req;
  logic [5:0]  up_addr;
  logic [7:0]  up_wdata;
  logic        up_ack;
  logic        dma_req, dma_wr;
  logic [18:0] dma_addr;
  logic [7:0]  dma_wdata, dma_rdata;
  logic        dma_ack;
  logic [18:0] va;
  logic [7:0]  vd_in, vd_out;
  logic        vd_oe, n_vrd, n_vwr, busy;

  int n_chk  = 0;
  int n_fail = 0;
  int n_viol = 0;

  always #5 clk28 = ~clk28;

  vram_arbiter #(.ACC_CYCLES(2), .DMA_MAX_WAIT(7)) dut (
    .clk28(clk28), .rst_n(rst_n),
    .scr_req(scr_req), .scr_addr(scr_addr),
    .scr_ack(scr_ack), .scr_data(scr_data),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .up_req(up_req), .up_addr(up_addr),
    .up_wdata(up_wdata), .up_ack(up_ack),
    .dma_req(dma_req), .dma_wr(dma_wr),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .va(va), .vd_in(vd_in), .vd_out(vd_out),
    .vd_oe(vd_oe), .n_vrd(n_vrd), .n_vwr(n_vwr),
    .busy(busy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk28);
    #1;
  endtask

  always @(negedge clk28) begin
    if (!n_vrd && !n_vwr) n_viol++;
    if (vd_oe && !n_vrd) n_viol++;
  end

  initial begin
    int ack_at, lows, gaps, cnt_a, cnt_b, seg;
    int scr_at, cpu_at, dma_at;
    logic wr_bad, got2;
    logic [7:0] vwr_mask, oe_mask, vrd_mask;
    logic [18:0] va_s;
    logic [7:0] vdo_s;
    logic oe_s;

    rst_n = 1'b0;
    scr_req = 0; scr_addr = 0;
    cpu_req = 0; cpu_wr = 0; cpu_addr = 0; cpu_wdata = 0;
    up_req = 0; up_addr = 0; up_wdata = 0;
    dma_req = 0; dma_wr = 0; dma_addr = 0; dma_wdata = 0;
    vd_in = 8'h00;
    tick(); tick();
    chk("rst_va", 32'(va), 0);
    chk("rst_strobes", {30'd0, n_vrd, n_vwr}, 3);
    chk("rst_oe_busy", {30'd0, vd_oe, busy}, 0);
    chk("rst_acks",
        {28'd0, scr_ack, cpu_ack, up_ack, dma_ack}, 0);
    rst_n = 1'b1;
    tick();

    // single CPU read
    cpu_req = 1; cpu_wr = 0; cpu_addr = 19'h0C123;
    vd_in = 8'hA5;
    ack_at = 0; lows = 0; wr_bad = 0; va_s = '0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 1) va_s = va;
      if (!n_vrd) lows++;
      if (!n_vwr) wr_bad = 1;
      if (cpu_ack) begin
        if (ack_at == 0) ack_at = i;
        cpu_req = 0;
      end
    end
    chk("rd_va_setup", 32'(va_s), 32'h0C123);
    chk("rd_vrd_low", lows, 2);
    chk("rd_ack_edge", ack_at, 4);
    chk("rd_rdata", 32'(cpu_rdata), 32'hA5);
    chk("rd_no_vwr", 32'(wr_bad), 0);
    chk("rd_idle", 32'(busy), 0);

    // screen, CPU write, DMA read on one edge
    vd_in = 8'h5A;
    scr_req = 1; scr_addr = 19'h00100;
    cpu_req = 1; cpu_wr = 1; cpu_addr = 19'h00200;
    cpu_wdata = 8'h3C;
    dma_req = 1; dma_wr = 0; dma_addr = 19'h00300;
    scr_at = 0; cpu_at = 0; dma_at = 0; gaps = 0;
    va_s = '0; vdo_s = '0; oe_s = 0;
    for (int i = 1; i <= 13; i++) begin
      tick();
      if (i <= 12 && !busy) gaps++;
      if (i == 5) begin
        va_s = va; vdo_s = vd_out; oe_s = vd_oe;
      end
      if (scr_ack) begin scr_at = i; scr_req = 0; end
      if (cpu_ack) begin cpu_at = i; cpu_req = 0; end
      if (dma_ack) begin dma_at = i; dma_req = 0; end
    end
    chk("pri_scr_ack", scr_at, 4);
    chk("pri_cpu_ack", cpu_at, 8);
    chk("pri_dma_ack", dma_at, 12);
    chk("pri_no_gap", gaps, 0);
    chk("pri_cpu_va", 32'(va_s), 32'h00200);
    chk("pri_cpu_vdo", {23'd0, oe_s, vdo_s}, 32'h13C);
    chk("pri_scr_data", 32'(scr_data), 32'h5A);
    chk("pri_dma_rdata", 32'(dma_rdata), 32'h5A);
    chk("pri_idle", 32'(busy), 0);

    // DMA starvation guard
    cpu_req = 1; cpu_wr = 0; cpu_addr = 19'h01000;
    dma_req = 1; dma_wr = 0; dma_addr = 19'h02000;
    seg = 0; cnt_a = 0; cnt_b = 0; got2 = 0;
    for (int i = 0; i < 120 && !got2; i++) begin
      tick();
      if (cpu_ack) begin
        if (seg == 0) cnt_a++;
        else cnt_b++;
      end
      if (dma_ack) begin
        if (seg == 0) seg = 1;
        else begin
          got2 = 1; cpu_req = 0; dma_req = 0;
        end
      end
    end
    chk("dma_done", 32'(got2), 1);
    chk("dma_first_losses", cnt_a, 7);
    chk("dma_second_losses", cnt_b, 7);
    tick();
    chk("dma_idle", 32'(busy), 0);

    // ULAplus palette write
    up_req = 1; up_addr = 6'h2A; up_wdata = 8'h5C;
    vwr_mask = 0; oe_mask = 0; vrd_mask = 0;
    ack_at = 0; lows = 0; va_s = '0; vdo_s = '0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 1) begin va_s = va; vdo_s = vd_out; end
      vwr_mask[i-1] = !n_vwr;
      oe_mask[i-1]  = vd_oe;
      vrd_mask[i-1] = !n_vrd;
      if (up_ack) begin lows++; up_req = 0; end
    end
    chk("up_va", 32'(va_s), 32'h1FFEA);
    chk("up_vd_out", 32'(vdo_s), 32'h5C);
    chk("up_vwr_shape", 32'(vwr_mask), 32'h06);
    chk("up_oe_shape", 32'(oe_mask), 32'h0F);
    chk("up_no_vrd", 32'(vrd_mask), 0);
    chk("up_ack_count", lows, 1);

    // reset during STROBE of a CPU write
    cpu_req = 1; cpu_wr = 1; cpu_addr = 19'h12345;
    cpu_wdata = 8'hE7;
    tick(); tick();
    chk("rs_in_strobe", {30'd0, n_vwr, vd_oe}, 1);
    rst_n = 0;
    tick();
    rst_n = 1;
    chk("rs_va", 32'(va), 0);
    chk("rs_pins", {29'd0, n_vwr, vd_oe, busy}, 4);
    chk("rs_rdata", {16'd0, cpu_rdata, scr_data}, 0);
    ack_at = 0; lows = 0; va_s = '0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 1) va_s = va;
      if (cpu_ack) begin
        lows++;
        if (ack_at == 0) ack_at = i;
        cpu_req = 0;
      end
    end
    chk("rs_regrant_va", 32'(va_s), 32'h12345);
    chk("rs_ack_edge", ack_at, 4);
    chk("rs_ack_count", lows, 1);

    // CPU pulse during screen STROBE is cancelled
    vd_in = 8'hC3;
    scr_req = 1; scr_addr = 19'h00ABC;
    scr_at = 0; lows = 0; cnt_a = 0; oe_s = 1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 2) begin cpu_req = 1; cpu_wr = 0; end
      if (i == 3) cpu_req = 0;
      if (cpu_ack) cnt_a++;
      if (scr_ack) begin scr_at = i; scr_req = 0; end
      if (i == 5) oe_s = busy;
      if (i >= 5 && (!n_vrd || !n_vwr)) lows++;
    end
    chk("pulse_scr_ack", scr_at, 4);
    chk("pulse_scr_data", 32'(scr_data), 32'hC3);
    chk("pulse_no_cpu_ack", cnt_a, 0);
    chk("pulse_idle", 32'(oe_s), 0);
    chk("pulse_no_access", lows, 0);

    chk("strobe_invariants", n_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
